sar_search: RTL

SAR_SEARCH -- requirements
Module: sar_search

---
 rtl/sar_search_pkg.sv | 6 +
 rtl/sar_watchdog.sv | 16 +
 rtl/sar_search.sv | 85 ++++++++
 3 files changed

// File: rtl/sar_search_pkg.sv
// sar_search_pkg: shared state encoding and default sizing for the SAR search block
package sar_search_pkg;
  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;
  localparam int W_DEF = 4;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/sar_watchdog.sv
// sar_watchdog: per-probe wait counter, expired once TIMEOUT cycles pass without a clear
module sar_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;
  assign expired = enable && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    cnt <= (!rst_n || clear) ? '0 : (enable && !expired) ? cnt + CW'(1) : cnt;
endmodule

// File: rtl/sar_search.sv
// sar_search: MSB-first successive-approximation search against an external comparator
module sar_search import sar_search_pkg::*; #(
  parameter int W = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [W-1:0] trial,
  output logic         trial_valid,
  input  logic         cmp_valid,
  input  logic         cmp_lt,
  input  logic         cmp_eq,
  input  logic         cmp_gt,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         found,
  output logic         err
);
  localparam int SW = $clog2(W);
  state_t state;
  logic [SW-1:0] step;
  logic [W-1:0] msb, bit_now, acc, acc_next;
  logic hit, flags_ok, last, expired, new_trial;
  assign msb = {1'b1, {(W-1){1'b0}}};
  assign bit_now = msb >> step;
  assign acc = trial & ~bit_now;
  assign acc_next = cmp_lt ? trial : acc;
  assign hit = state == PROBE && cmp_valid;
  assign flags_ok = (cmp_lt ^ cmp_eq ^ cmp_gt) && !(cmp_lt && cmp_eq && cmp_gt);
  assign last = step == SW'(W - 1);
  assign new_trial = (state == IDLE && start) || (hit && flags_ok && !cmp_eq && !last);
  assign trial_valid = state == PROBE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  sar_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk(clk),
    .rst_n(rst_n),
    .clear(new_trial),
    .enable(state == PROBE),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      step <= '0;
      trial <= '0;
      result <= '0;
      found <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= PROBE;
          step <= '0;
          trial <= msb;
          result <= '0;
          found <= 1'b0;
          err <= 1'b0;
        end
        PROBE: if (hit && !flags_ok) begin
          state <= DONE;
          err <= 1'b1;
          result <= '0;
        end else if (hit && cmp_eq) begin
          state <= DONE;
          found <= 1'b1;
          result <= trial;
        end else if (hit && last) begin
          state <= DONE;
          result <= acc_next;
        end else if (hit) begin
          step <= step + SW'(1);
          trial <= acc_next | (bit_now >> 1);
        end else if (expired) begin
          state <= DONE;
          err <= 1'b1;
          result <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
